// File: rtl/multicore_mem_arbiter_pkg.sv
// Shared types for the multicore memory arbiter.
// FSM encoding and the GRANT_ID width helper.
package multicore_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int LAT_W = 2;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicore_mem_arbiter_pick.sv
// Combinational round-robin picker: first eligible core
// searching upward from last_id+1, wrapping modulo N.
module rr_arbiter_pick
  import multicore_mem_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        eligible,
  input  logic [id_w(N)-1:0]  last_id,
  output logic [N-1:0]        grant,
  output logic [id_w(N)-1:0]  grant_id
);

  localparam int IW = id_w(N);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = last_id;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(last_id) + i;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM
// among NUM_CORES cores, plus a sticky ALL_DONE barrier.
module multicore_mem_arbiter
  import multicore_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                        MAIN_CLOCK,
  input  logic                        RESET,
  input  logic [NUM_CORES-1:0]        CORE_REQ,
  input  logic [NUM_CORES-1:0]        CORE_WE,
  input  logic [NUM_CORES*ADDR_W-1:0] CORE_ADDR,
  input  logic [NUM_CORES*DATA_W-1:0] CORE_WDATA,
  input  logic [NUM_CORES-1:0]        CORE_DONE,
  output logic [NUM_CORES-1:0]        CORE_ACK,
  output logic [DATA_W-1:0]           CORE_RDATA,
  output logic [ADDR_W-1:0]           RAM_ADDR,
  output logic                        RAM_WE,
  output logic [DATA_W-1:0]           RAM_WDATA,
  input  logic [DATA_W-1:0]           RAM_RDATA,
  output logic [id_w(NUM_CORES)-1:0]  GRANT_ID,
  output logic                        BUSY,
  output logic                        ALL_DONE
);

  localparam int ID_W = id_w(NUM_CORES);

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] ack_d;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] pick_grant;
  logic [NUM_CORES-1:0] done_q;
  logic [ID_W-1:0]      pick_id, gid_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d, rdata_d;
  logic                 we_d;

  // A just-acked core is masked for one IDLE cycle so a
  // lingering REQ does not replay the same transaction.
  assign eligible = CORE_REQ & ~mask_q;

  rr_arbiter_pick #(
    .N(NUM_CORES)
  ) u_pick (
    .eligible (eligible),
    .last_id  (GRANT_ID),
    .grant    (pick_grant),
    .grant_id (pick_id)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    mask_d  = '0;
    ack_d   = '0;
    gid_d   = GRANT_ID;
    addr_d  = RAM_ADDR;
    we_d    = RAM_WE;
    wdata_d = RAM_WDATA;
    rdata_d = CORE_RDATA;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_ISSUE;
          gid_d   = pick_id;
          we_d    = |(CORE_WE & pick_grant);
          addr_d  = CORE_ADDR[int'(pick_id)*ADDR_W +: ADDR_W];
          wdata_d = CORE_WDATA[int'(pick_id)*DATA_W +: DATA_W];
        end
      end
      ST_ISSUE: begin
        we_d = 1'b0;
        if (RAM_WE) begin
          state_d = ST_RESP;
        end else begin
          lat_d   = LAT_W'(RD_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          rdata_d = RAM_RDATA;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: begin
        ack_d[GRANT_ID]  = 1'b1;
        mask_d[GRANT_ID] = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      mask_q     <= '0;
      CORE_ACK   <= '0;
      CORE_RDATA <= '0;
      RAM_ADDR   <= '0;
      RAM_WE     <= 1'b0;
      RAM_WDATA  <= '0;
      GRANT_ID   <= ID_W'(NUM_CORES - 1);
      BUSY       <= 1'b0;
      done_q     <= '0;
      ALL_DONE   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      mask_q     <= mask_d;
      CORE_ACK   <= ack_d;
      CORE_RDATA <= rdata_d;
      RAM_ADDR   <= addr_d;
      RAM_WE     <= we_d;
      RAM_WDATA  <= wdata_d;
      GRANT_ID   <= gid_d;
      BUSY       <= (state_d != ST_IDLE);
      done_q     <= done_q | CORE_DONE;
      ALL_DONE   <= &done_q;
    end
  end

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed self-checking bench for multicore_mem_arbiter
// with a 2-cycle-latency RAM model.
module tb_multicore_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;

  logic           clk;
  logic           rst;
  logic [NC-1:0]  core_req;
  logic [NC-1:0]  core_we;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  core_ack;
  logic [DW-1:0]  core_rdata;
  logic [AW-1:0]  ram_addr;
  logic           ram_we;
  logic [DW-1:0]  ram_wdata;
  logic [DW-1:0]  ram_rdata;
  logic [1:0]     grant_id;
  logic           busy;
  logic           all_done;

  int nvec = 0;
  int nerr = 0;

  multicore_mem_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)
  ) dut (
    .MAIN_CLOCK (clk),
    .RESET      (rst),
    .CORE_REQ   (core_req),
    .CORE_WE    (core_we),
    .CORE_ADDR  (core_addr),
    .CORE_WDATA (core_wdata),
    .CORE_DONE  (core_done),
    .CORE_ACK   (core_ack),
    .CORE_RDATA (core_rdata),
    .RAM_ADDR   (ram_addr),
    .RAM_WE     (ram_we),
    .RAM_WDATA  (ram_wdata),
    .RAM_RDATA  (ram_rdata),
    .GRANT_ID   (grant_id),
    .BUSY       (busy),
    .ALL_DONE   (all_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] mem [256];
  logic [DW-1:0] p0, p1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    p0 <= mem[ram_addr[7:0]];
    p1 <= p0;
  end
  assign ram_rdata = p1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int c, input logic we,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      input int exp_lat,
                      input logic [DW-1:0] exp_rd);
    int n;
    logic [NC-1:0] oh;
    oh = '0;
    oh[c] = 1'b1;
    core_req = oh;
    core_we[c] = we;
    core_addr[c*AW +: AW] = a;
    core_wdata[c*DW +: DW] = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (core_ack == '0 && n < 20);
    nvec++;
    if (core_ack == '0) begin
      nerr++;
      $error("FAIL timeout: no ACK for core %0d", c);
    end
    chk("latency", n, exp_lat);
    chk("ack_onehot", core_ack, oh);
    if (!we) chk("rdata", core_rdata, exp_rd);
    core_req = '0;
    tick();
  endtask

  logic [NC-1:0] ack_id_q [$];
  int            ack_t_q  [$];
  logic [NC-1:0] exp_oh;
  logic          stray;

  initial begin
    rst = 1'b1;
    core_req = '0;
    core_we = '0;
    core_addr = '0;
    core_wdata = '0;
    core_done = '0;
    tick();
    tick();
    chk("rst_ack", core_ack, 4'b0000);
    chk("rst_gid", grant_id, 2'd3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_alldone", all_done, 1'b0);
    chk("rst_rdata", core_rdata, 16'h0000);
    rst = 1'b0;
    tick();

    core_req = 4'b0100;
    core_we = 4'b0100;
    core_addr[2*AW +: AW] = 16'h0010;
    core_wdata[2*DW +: DW] = 16'hBEEF;
    tick();
    chk("w_we_hi", ram_we, 1'b1);
    chk("w_addr", ram_addr, 16'h0010);
    chk("w_data", ram_wdata, 16'hBEEF);
    chk("w_gid", grant_id, 2'd2);
    chk("w_busy", busy, 1'b1);
    tick();
    chk("w_we_lo", ram_we, 1'b0);
    chk("w_noack", core_ack, 4'b0000);
    tick();
    chk("w_ack", core_ack, 4'b0100);
    core_req = '0;
    tick();
    chk("w_ack_pulse", core_ack, 4'b0000);
    chk("w_idle", busy, 1'b0);

    xact(0, 1'b1, 16'h0020, 16'h1234, 3, 16'h0);
    xact(1, 1'b0, 16'h0020, 16'h0, 5, 16'h1234);
    xact(2, 1'b1, 16'h0030, 16'h5555, 3, 16'h0);
    chk("rdata_hold", core_rdata, 16'h1234);
    xact(3, 1'b0, 16'h0010, 16'h0, 5, 16'hBEEF);
    chk("gid_last3", grant_id, 2'd3);

    core_we = 4'b1111;
    core_addr = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
    core_req = 4'b1111;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (core_ack != '0) begin
        ack_id_q.push_back(core_ack);
        ack_t_q.push_back(t);
      end
    end
    core_req = '0;
    tick();
    tick();
    tick();
    chk("rr_count", ack_id_q.size(), 5);
    for (int k = 0; k < 5 && k < ack_id_q.size(); k++) begin
      exp_oh = 4'b0001 << (k % NC);
      chk("rr_order", ack_id_q[k], exp_oh);
      chk("rr_time", ack_t_q[k], 3 * (k + 1));
    end

    core_we = 4'b0001;
    core_addr[0 +: AW] = 16'h0050;
    core_req = 4'b0001;
    tick();
    tick();
    tick();
    chk("m_ack1", core_ack, 4'b0001);
    tick();
    chk("m_masked", busy, 1'b0);
    tick();
    chk("m_regrant", busy, 1'b1);
    tick();
    tick();
    chk("m_ack2", core_ack, 4'b0001);
    core_req = '0;
    tick();
    tick();
    chk("m_idle", busy, 1'b0);

    core_done = 4'b1000; tick(); core_done = '0; tick();
    core_done = 4'b0001; tick(); core_done = '0; tick();
    core_done = 4'b0100; tick(); core_done = '0; tick();
    chk("d_not_yet", all_done, 1'b0);
    core_done = 4'b0010;
    tick();
    core_done = '0;
    chk("d_latch_cyc", all_done, 1'b0);
    tick();
    chk("d_rise", all_done, 1'b1);
    tick();
    tick();
    tick();
    chk("d_sticky", all_done, 1'b1);

    core_we = 4'b0000;
    core_addr[0 +: AW] = 16'h0020;
    core_req = 4'b0001;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("r_ack", core_ack, 4'b0000);
    chk("r_we", ram_we, 1'b0);
    chk("r_gid", grant_id, 2'd3);
    chk("r_busy", busy, 1'b0);
    chk("r_alldone", all_done, 1'b0);
    chk("r_rdata", core_rdata, 16'h0000);
    core_req = '0;
    rst = 1'b0;
    stray = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (core_ack != '0) stray = 1'b1;
    end
    chk("r_no_ack", stray, 1'b0);
    xact(0, 1'b0, 16'h0020, 16'h0, 5, 16'h1234);
    chk("r_gid0", grant_id, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
